pdm_audio_input: RTL and testbench

Stereo PDM microphone receiver. It is the capture-side counterpart of the delta-sigma audio output path. It generates the PDM bit clock and samples two microphones that share one data line (L at the end of the high phase, R at the end of the low phase). Each channel is decimated with a boxcar ones-counter into 16-bit unsigned PCM and queued in a sync FIFO. The CPU drains the FIFO with a toggle handshake, in the same packing as the output path: data[31:16] = R, data[15:0] = L.

---
 rtl/pdm_audio_input.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pdm_audio_input.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_audio_input.sv
// pdm_audio_input
// Stereo PDM microphone receiver. It generates the PDM bit clock and samples
// two microphones that share one data line: L at the end of the high phase,
// R at the end of the low phase. Each channel is decimated by a boxcar
// ones-counter into 16-bit unsigned PCM. Samples are queued in a sync FIFO,
// which the CPU drains with a toggle handshake.
// Packing: data[31:16] = R, data[15:0] = L.
// Build option: define AUDIO_INPUT_MONO_EN for a mono build. In that build the
// R accumulator is removed and the L sample is copied into data[31:16].
module pdm_audio_input #(
    parameter int FIFO_DEPTH_IN_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  pdm_clock_divider,
    input  logic [15:0]                 decimation,
    input  logic [3:0]                  gain_shift,
    output logic                        ext_pdm_clk,
    input  logic                        ext_pdm_data,
    input  logic                        read_toggle,
    output logic [31:0]                 data,
    output logic                        empty,
    output logic [FIFO_DEPTH_IN_BITS:0] count,
    output logic                        overflow,
    input  logic                        clear_overflow
);

    localparam int AW    = FIFO_DEPTH_IN_BITS;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

`ifdef AUDIO_INPUT_MONO_EN
    localparam int NUM_CH = 1;
`else
    localparam int NUM_CH = 2;
`endif

    // Adds one PDM bit to a 17-bit ones-count. The count sticks at all-ones
    // rather than wrapping.
    function automatic logic [16:0] sat_inc(input logic [16:0] acc, input logic bit_in);
        if (acc == 17'h1FFFF) begin
            return acc;
        end
        return acc + {16'd0, bit_in};
    endfunction

    // Applies the gain shift at 33 bits so that no bits are lost, then clamps
    // the result to 16-bit full scale.
    function automatic logic [15:0] scale_sat(input logic [16:0] acc, input logic [3:0] shift);
        logic [32:0] wide;
        wide = {16'd0, acc} << shift;
        if (wide > 33'h0_0000_FFFF) begin
            return 16'hFFFF;
        end
        return wide[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic r_sync_meta;
    logic r_sync_bit;

    // Two-flop synchronizer for the asynchronous PDM data line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_sync_bit  <= 1'b0;
        end else begin
            r_sync_meta <= ext_pdm_data;
            r_sync_bit  <= r_sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // PDM clock generation and sampling ticks
    // ------------------------------------------------------------------
    logic [7:0] r_div_cnt;
    logic       r_pdm_clk;
    logic       w_reload;
    logic [7:0] w_div_load;
    logic       w_tick_l;
    logic       w_tick_r;

    // Divider values below 2 are raised to 2. This keeps each half-period at
    // least 3 clk long, which leaves room for the synchronizer latency.
    assign w_div_load = (pdm_clock_divider < 8'd2) ? 8'd2 : pdm_clock_divider;
    assign w_reload   = (r_div_cnt == 8'd0);
    assign w_tick_l   = w_reload &  r_pdm_clk;
    assign w_tick_r   = w_reload & ~r_pdm_clk;

    // Half-period down-counter. The divider input is read only on reload, so a
    // new setting takes effect at the next phase boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= 8'd0;
            r_pdm_clk <= 1'b0;
        end else if (w_reload) begin
            r_div_cnt <= w_div_load;
            r_pdm_clk <= ~r_pdm_clk;
        end else begin
            r_div_cnt <= r_div_cnt - 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Period counting / decimation
    // ------------------------------------------------------------------
    logic [15:0] r_per_cnt;
    logic        w_sample_done;

    assign w_sample_done = w_tick_r && (r_per_cnt == decimation);

    // Counts completed PDM periods. It restarts on each sample boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_per_cnt <= 16'd0;
        end else if (w_tick_r) begin
            if (w_sample_done) begin
                r_per_cnt <= 16'd0;
            end else begin
                r_per_cnt <= r_per_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel boxcar accumulators (index 0 = L, index 1 = R)
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]       w_tick_ch;
    logic [NUM_CH-1:0][15:0] w_pcm;
    logic [31:0]             w_sample;

`ifdef AUDIO_INPUT_MONO_EN
    assign w_tick_ch = w_tick_l;
`else
    assign w_tick_ch = {w_tick_r, w_tick_l};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [16:0] r_acc;
            logic [16:0] w_acc_upd;

            // The completed sample includes any bit taken on the same tick.
            // For R, that is the bit taken on the closing tick of the period.
            assign w_acc_upd = w_tick_ch[gi] ? sat_inc(r_acc, r_sync_bit) : r_acc;
            assign w_pcm[gi] = scale_sat(w_acc_upd, gain_shift);

            // Ones-counter: counts on its own tick and clears when a sample is taken
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_acc <= 17'd0;
                end else if (w_sample_done) begin
                    r_acc <= 17'd0;
                end else begin
                    r_acc <= w_acc_upd;
                end
            end
        end
    endgenerate

`ifdef AUDIO_INPUT_MONO_EN
    assign w_sample = {w_pcm[0], w_pcm[0]};
`else
    assign w_sample = {w_pcm[1], w_pcm[0]};
`endif

    // ------------------------------------------------------------------
    // Read handshake
    // ------------------------------------------------------------------
    logic r_toggle;
    logic r_toggle_prev;

    // Records the toggle history. An edge on read_toggle requests one pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_toggle      <= 1'b0;
            r_toggle_prev <= 1'b0;
        end else begin
            r_toggle      <= read_toggle;
            r_toggle_prev <= r_toggle;
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_data;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_full = (r_count == FULL_COUNT);
    // A toggle that arrives while the FIFO is empty is simply lost.
    assign w_pop  = (r_toggle != r_toggle_prev) && (r_count != '0);
    // A full FIFO still accepts a sample if it is popped in the same cycle.
    assign w_push = w_sample_done && (!w_full || w_pop);
    assign w_drop = w_sample_done && w_full && !w_pop;

    // Storage array. It has no reset, so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sample;
        end
    end

    // Registered read port. When the FIFO is full and a push and a pop happen
    // together, both use the same slot. The read returns the old head
    // because the write lands at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= 32'd0;
        end else if (w_pop) begin
            r_data <= r_mem[r_rd_ptr];
        end
    end

    // Pointers wrap naturally. The occupancy count separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag. A drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign ext_pdm_clk = r_pdm_clk;
    assign data        = r_data;
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_pdm_audio_input.sv
// Testbench for pdm_audio_input. Reads are checked by a scoreboard: each read
// request queues its expected data word, and a monitor pops and compares when
// the DUT data register updates. Status outputs are checked inline.
`timescale 1ns/1ps
module tb_pdm_audio_input;

    localparam int AWB = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     pdm_clock_divider;
    logic [15:0]    decimation;
    logic [3:0]     gain_shift;
    logic           ext_pdm_clk;
    logic           ext_pdm_data;
    logic           read_toggle;
    logic [31:0]    data;
    logic           empty;
    logic [AWB:0]   count;
    logic           overflow;
    logic           clear_overflow;

    always #5 clk = ~clk;

    pdm_audio_input #(.FIFO_DEPTH_IN_BITS(AWB)) dut (
        .clk               (clk),
        .reset             (reset),
        .pdm_clock_divider (pdm_clock_divider),
        .decimation        (decimation),
        .gain_shift        (gain_shift),
        .ext_pdm_clk       (ext_pdm_clk),
        .ext_pdm_data      (ext_pdm_data),
        .read_toggle       (read_toggle),
        .data              (data),
        .empty             (empty),
        .count             (count),
        .overflow          (overflow),
        .clear_overflow    (clear_overflow)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    // Microphone data pattern: 0 constant 0, 1 constant 1,
    // 2 = 1 in the high phase and 0 in the low phase,
    // 3 = the bit alternates on every PDM period.
    int   data_mode = 1;
    logic alt_bit   = 1'b0;
    logic prev_pclk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Drives the PDM data line away from the clk edge
    always @(negedge clk) begin
        if (reset) begin
            alt_bit   = 1'b0;
            prev_pclk = 1'b0;
        end else begin
            if (ext_pdm_clk && !prev_pclk) alt_bit = ~alt_bit;
            prev_pclk = ext_pdm_clk;
        end
        case (data_mode)
            0:       ext_pdm_data = 1'b0;
            1:       ext_pdm_data = 1'b1;
            2:       ext_pdm_data = ext_pdm_clk;
            default: ext_pdm_data = alt_bit;
        endcase
    end

    // Delay line on read_toggle. data changes on the 2nd edge after a
    // toggle, so the compare runs on the negedge after that edge.
    logic rt_d1 = 1'b0, rt_d2 = 1'b0, rt_d3 = 1'b0;
    always @(posedge clk) begin
        rt_d1 <= read_toggle;
        rt_d2 <= rt_d1;
        rt_d3 <= rt_d2;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rt_d2 != rt_d3) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read_unexpected: got 0x%08h expected no read", data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_data", data, mon_exp);
            end
        end
    end

    task automatic do_read(input logic [31:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        read_toggle = ~read_toggle;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset(input int mode, input logic [15:0] dec);
        @(negedge clk);
        reset             = 1'b1;
        data_mode         = mode;
        decimation        = dec;
        gain_shift        = 4'd12;
        pdm_clock_divider = 8'd4;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_count(input int n, input int budget);
        int g;
        g = 0;
        while (int'(count) < n && g < budget) begin
            @(negedge clk);
            g++;
        end
        if (int'(count) < n) begin
            total++;
            bad++;
            $display("FAIL wait_count: got %0d expected >= %0d", count, n);
        end
    endtask

    // Waits for the next ext_pdm_clk edge, then counts clk cycles to the edge after it
    task automatic measure_half(output int n);
        logic lv;
        int   g;
        lv = ext_pdm_clk;
        g  = 0;
        while (ext_pdm_clk == lv && g < 100) begin
            @(negedge clk);
            g++;
        end
        lv = ext_pdm_clk;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ext_pdm_clk == lv && n < 100);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int g;
        reset             = 1'b1;
        pdm_clock_divider = 8'd4;
        decimation        = 16'd15;
        gain_shift        = 4'd12;
        read_toggle       = 1'b0;
        clear_overflow    = 1'b0;
        data_mode         = 1;
        repeat (3) @(negedge clk);

        // Outputs while reset is held
        check("rst_pdm_clk", {31'd0, ext_pdm_clk}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;

        // Half-period of the PDM clock. Divider values below 2 behave as 2.
        measure_half(n);
        check("half_div4_a", n, 5);
        measure_half(n);
        check("half_div4_b", n, 5);
        pdm_clock_divider = 8'd0;
        measure_half(n);
        check("half_div0", n, 3);
        pdm_clock_divider = 8'd1;
        measure_half(n);
        check("half_div1", n, 3);

        // Constant 1. The first sample after reset sees 15 ones per channel,
        // because the first tick_r reads the cleared synchronizer: 15<<12 = 0xF000.
        // Later samples see 16 ones: 16<<12 saturates to 0xFFFF.
        apply_reset(1, 16'd15);
        wait_count(1, 400);
        n = 0;
        while (int'(count) < 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("sample_interval", n, 160);
        check("count_two", {27'd0, count}, 32'd2);
        do_read(32'hF000F000);
        do_read(32'hFFFFFFFF);
        check("count_after_reads", {27'd0, count}, 32'd0);
        check("empty_after_reads", {31'd0, empty}, 32'd1);

        // High phase = 1, low phase = 0: L is full scale, R is zero
        apply_reset(2, 16'd15);
        wait_count(2, 400);
        do_read(32'h0000F000);
        do_read(32'h0000FFFF);

        // Bit alternates per period: 8 ones per channel, 8<<12 = 0x8000
        apply_reset(3, 16'd15);
        wait_count(2, 400);
        do_read(32'h80008000);
        do_read(32'h80008000);

        // Overflow. decimation=3, so the first sample is 0x3000 per channel
        // and later ones are 0x4000.
        apply_reset(1, 16'd3);
        g = 0;
        while (overflow !== 1'b1 && g < 1500) begin
            @(negedge clk);
            g++;
        end
        decimation = 16'hFFFF;   // no further samples during this test
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_count_full", {27'd0, count}, 32'd16);
        check("ovf_not_empty", {31'd0, empty}, 32'd0);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        do_read(32'h30003000);
        check("ovf_count_15", {27'd0, count}, 32'd15);
        do_read(32'h40004000);
        check("ovf_count_14", {27'd0, count}, 32'd14);

        // A toggle while empty is lost. Then reset mid-operation.
        apply_reset(1, 16'd3);
        do_read(32'h00000000);
        wait_count(1, 200);
        check("empty_toggle_count", {27'd0, count}, 32'd1);
        check("empty_toggle_data", data, 32'd0);
        do_read(32'h30003000);
        wait_count(1, 200);
        g = 0;
        while (ext_pdm_clk !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("pre_reset_pdm_clk", {31'd0, ext_pdm_clk}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_pdm_clk", {31'd0, ext_pdm_clk}, 32'd0);
        check("mid_rst_data", data, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_count", {27'd0, count}, 32'd0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
